register_dump_reader: RTL and testbench

Sequential read-side master for `register_block`. On `start` it walks a contiguous range of register addresses, two per fetch via both read ports, and streams each word out on a valid/ready interface. It also provides a running XOR checksum. It sits between the register file and debug/verification logic, so register contents can be dumped without disturbing the datapath.

---
 rtl/register_dump_pkg.sv | 18 +
 rtl/dump_pair_buffer.sv | 69 ++++++
 rtl/register_dump_reader.sv | 153 +++++++++++++++
 tb/tb_register_dump_reader.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/register_dump_pkg.sv
// Shared types and constants for the register dump reader and its pair buffer.
package register_dump_pkg;

  localparam int unsigned NUM_REGS_DEF = 32;
  localparam int unsigned ADDR_W_DEF   = 5;
  localparam int unsigned DATA_W_DEF   = 32;

  localparam logic [31:0] BYTE_MASK = 32'h000000FF;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EMIT0,
    EMIT1,
    DONE
  } dump_state_e;

endpackage

// File: rtl/dump_pair_buffer.sv
// Two-entry word buffer filled from both register read ports in one cycle,
// with optional low-byte masking and per-slot last/valid flags.
module dump_pair_buffer
  import register_dump_pkg::*;
#(
  parameter int unsigned NUM_REGS = NUM_REGS_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              byte_mode_i,
  input  logic              sel_i,
  input  logic [ADDR_W-1:0] ptr_i,
  input  logic [ADDR_W-1:0] last_reg_i,
  input  logic [DATA_W-1:0] data0_i,
  input  logic [DATA_W-1:0] data1_i,
  output logic              slot1_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic [ADDR_W-1:0] out_addr_o,
  output logic              out_last_o
);

  localparam int unsigned AW1 = ADDR_W + 1;

  logic [ADDR_W:0]   nxt_d;
  logic [DATA_W-1:0] mask_d;
  logic              valid1_d;
  logic              last1_d;

  logic [DATA_W-1:0] data0_q, data1_q;
  logic [ADDR_W-1:0] addr0_q, addr1_q;
  logic              last0_q, last1_q, valid1_q;

  // Extra address bit keeps ptr = max from wrapping the second slot to 0.
  always_comb begin
    nxt_d    = {1'b0, ptr_i} + AW1'(1);
    valid1_d = (nxt_d <= {1'b0, last_reg_i}) && (nxt_d < AW1'(NUM_REGS));
    last1_d  = (nxt_d == {1'b0, last_reg_i});
    mask_d   = byte_mode_i ? DATA_W'(BYTE_MASK) : '1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data0_q  <= '0;
      data1_q  <= '0;
      addr0_q  <= '0;
      addr1_q  <= '0;
      last0_q  <= 1'b0;
      last1_q  <= 1'b0;
      valid1_q <= 1'b0;
    end else if (load_i) begin
      data0_q  <= data0_i & mask_d;
      data1_q  <= data1_i & mask_d;
      addr0_q  <= ptr_i;
      addr1_q  <= nxt_d[ADDR_W-1:0];
      last0_q  <= !valid1_d;
      last1_q  <= last1_d;
      valid1_q <= valid1_d;
    end
  end

  assign slot1_valid_o = valid1_q;
  assign out_data_o    = sel_i ? data1_q : data0_q;
  assign out_addr_o    = sel_i ? addr1_q : addr0_q;
  assign out_last_o    = sel_i ? last1_q : last0_q;

endmodule

// File: rtl/register_dump_reader.sv
// Walks a register address range two words per fetch and streams each word
// over valid/ready, keeping a running XOR checksum of accepted words.
module register_dump_reader
  import register_dump_pkg::*;
#(
  parameter int unsigned NUM_REGS = NUM_REGS_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_reg,
  input  logic [ADDR_W-1:0] last_reg,
  input  logic              byte_mode,
  output logic [ADDR_W-1:0] read_reg1,
  output logic [ADDR_W-1:0] read_reg2,
  output logic              byteOperations,
  input  logic [DATA_W-1:0] read_data1,
  input  logic [DATA_W-1:0] read_data2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

  dump_state_e       state_q;
  logic [ADDR_W-1:0] ptr_q, last_q;
  logic              mode_q;
  logic [ADDR_W-1:0] read_reg1_q, read_reg2_q;
  logic              byteops_q, out_valid_q, busy_q, done_q;
  logic [DATA_W-1:0] checksum_q;

  logic              slot1_valid;
  logic              hs;

  assign hs = out_valid_q && out_ready;

  dump_pair_buffer #(
    .NUM_REGS(NUM_REGS),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W)
  ) u_buf (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_i       (state_q == FETCH),
    .byte_mode_i  (mode_q),
    .sel_i        (state_q == EMIT1),
    .ptr_i        (ptr_q),
    .last_reg_i   (last_q),
    .data0_i      (read_data1),
    .data1_i      (read_data2),
    .slot1_valid_o(slot1_valid),
    .out_data_o   (out_data),
    .out_addr_o   (out_addr),
    .out_last_o   (out_last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      last_q      <= '0;
      mode_q      <= 1'b0;
      read_reg1_q <= '0;
      read_reg2_q <= '0;
      byteops_q   <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      checksum_q  <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            ptr_q      <= first_reg;
            last_q     <= last_reg;
            mode_q     <= byte_mode;
            checksum_q <= '0;
            if (first_reg > last_reg) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q     <= FETCH;
              busy_q      <= 1'b1;
              byteops_q   <= byte_mode;
              read_reg1_q <= first_reg;
              read_reg2_q <= first_reg + ADDR_W'(1);
            end
          end
        end
        FETCH: begin
          state_q     <= EMIT0;
          read_reg1_q <= '0;
          read_reg2_q <= '0;
          out_valid_q <= 1'b1;
        end
        EMIT0: begin
          if (hs) begin
            checksum_q <= checksum_q ^ out_data;
            if (slot1_valid) begin
              state_q <= EMIT1;
            end else begin
              state_q     <= DONE;
              out_valid_q <= 1'b0;
              busy_q      <= 1'b0;
              byteops_q   <= 1'b0;
              done_q      <= 1'b1;
            end
          end
        end
        EMIT1: begin
          if (hs) begin
            checksum_q  <= checksum_q ^ out_data;
            out_valid_q <= 1'b0;
            // Slot 1's last flag is exactly "ptr + 1 == last_reg".
            if (out_last) begin
              state_q   <= DONE;
              busy_q    <= 1'b0;
              byteops_q <= 1'b0;
              done_q    <= 1'b1;
            end else begin
              state_q     <= FETCH;
              ptr_q       <= ptr_q + ADDR_W'(2);
              read_reg1_q <= ptr_q + ADDR_W'(2);
              read_reg2_q <= ptr_q + ADDR_W'(3);
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign read_reg1      = read_reg1_q;
  assign read_reg2      = read_reg2_q;
  assign byteOperations = byteops_q;
  assign out_valid      = out_valid_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign checksum       = checksum_q;

endmodule

// File: tb/tb_register_dump_reader.sv
// Scoreboard bench: stimulus pushes expected beats, a negedge monitor pops and
// compares each handshaken word against a simple register-file model.
module tb_register_dump_reader;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] first_reg = '0;
  logic [AW-1:0] last_reg = '0;
  logic          byte_mode = 1'b0;
  logic [AW-1:0] read_reg1, read_reg2;
  logic          byteOperations;
  logic [DW-1:0] read_data1, read_data2;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_addr;
  logic          out_last;
  logic          busy, done;
  logic [DW-1:0] checksum;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    fails = 0;
  int    ready_mode = 0;

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] reg_word(input logic [AW-1:0] a);
    if (a == '0) return '0;
    return 32'hA5000000 | DW'(a);
  endfunction

  assign read_data1 = reg_word(read_reg1);
  assign read_data2 = reg_word(read_reg2);

  register_dump_reader #(
    .NUM_REGS(32),
    .ADDR_W  (AW),
    .DATA_W  (DW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .first_reg     (first_reg),
    .last_reg      (last_reg),
    .byte_mode     (byte_mode),
    .read_reg1     (read_reg1),
    .read_reg2     (read_reg2),
    .byteOperations(byteOperations),
    .read_data1    (read_data1),
    .read_data2    (read_data2),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_addr      (out_addr),
    .out_last      (out_last),
    .busy          (busy),
    .done          (done),
    .checksum      (checksum)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Consumer ready pattern: 0 = always ready, 1 = toggling, else random.
  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ~out_ready;
      default: out_ready = 1'($urandom);
    endcase
  end

  // Monitor: stream stability under stall, idle read ports, scoreboard pops.
  initial begin
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic [AW-1:0] prev_addr = '0;
    logic          prev_last = 1'b0;
    beat_t         b;
    forever begin
      @(negedge clk);
      if (prev_stall) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", out_data, prev_data);
        check("stall_addr", 32'(out_addr), 32'(prev_addr));
        check("stall_last", 32'(out_last), 32'(prev_last));
      end
      if (!busy) begin
        check("idle_read_reg1", 32'(read_reg1), 32'd0);
        check("idle_read_reg2", 32'(read_reg2), 32'd0);
      end
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_word: got addr=%0d data=%h, want no word", out_addr, out_data);
        end else begin
          b = exp_q.pop_front();
          check("word_data", out_data, b.data);
          check("word_addr", 32'(out_addr), 32'(b.addr));
          check("word_last", 32'(out_last), 32'(b.last));
        end
      end
      prev_stall = rst_n && out_valid && !out_ready;
      prev_data  = out_data;
      prev_addr  = out_addr;
      prev_last  = out_last;
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_read_reg1"}, 32'(read_reg1), 32'd0);
    check({tag, "_read_reg2"}, 32'(read_reg2), 32'd0);
    check({tag, "_byteops"}, 32'(byteOperations), 32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_data"}, out_data, 32'd0);
    check({tag, "_out_addr"}, 32'(out_addr), 32'd0);
    check({tag, "_out_last"}, 32'(out_last), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_checksum"}, checksum, 32'd0);
  endtask

  // One dump: expected words come straight from the address range.
  task automatic run_dump(input logic [AW-1:0] f, input logic [AW-1:0] l,
                          input logic m, input int rmode, input bit junk);
    logic [DW-1:0] cs, w;
    beat_t         b;
    int            n, exp_done, cyc, first_v;
    bit            seen_done;
    ready_mode = rmode;
    cs = '0;
    n  = 0;
    for (int a = int'(f); a <= int'(l); a++) begin
      w = reg_word(AW'(a));
      if (m) w = w & 32'h000000FF;
      b.addr = AW'(a);
      b.data = w;
      b.last = (a == int'(l));
      exp_q.push_back(b);
      cs = cs ^ w;
      n++;
    end
    exp_done = (n == 0) ? 1 : 1 + (n + 1) / 2 + n;

    @(negedge clk);
    start     = 1'b1;
    first_reg = f;
    last_reg  = l;
    byte_mode = m;
    @(posedge clk);
    #1 start = 1'b0;

    first_v   = -1;
    seen_done = 1'b0;
    for (cyc = 1; cyc <= 400; cyc++) begin
      @(negedge clk);
      if (out_valid && first_v < 0) first_v = cyc;
      if (done) begin
        seen_done = 1'b1;
        break;
      end
      check("busy_during_dump", 32'(busy), 32'd1);
      check("byteops_during_dump", 32'(byteOperations), 32'(m));
      if (junk) begin
        start     = 1'($urandom);
        first_reg = AW'($urandom);
        last_reg  = AW'($urandom);
        byte_mode = 1'($urandom);
      end
    end
    start = 1'b0;

    if (!seen_done) begin
      checks++;
      fails++;
      $display("FAIL done_timeout: got no done within 400 cycles, want done (range %0d..%0d)", f, l);
    end else begin
      check("done_busy_low", 32'(busy), 32'd0);
      check("done_byteops_low", 32'(byteOperations), 32'd0);
      check("done_out_valid_low", 32'(out_valid), 32'd0);
      check("checksum", checksum, cs);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      if (rmode == 0) check("done_cycle", 32'(cyc), 32'(exp_done));
      check("first_valid_cycle", 32'(first_v), (n == 0) ? 32'hFFFFFFFF : 32'd2);
    end
    exp_q.delete();
  endtask

  task automatic reset_mid_dump();
    beat_t b;
    ready_mode = 0;
    for (int a = 0; a <= 7; a++) begin
      b.addr = AW'(a);
      b.data = reg_word(AW'(a));
      b.last = (a == 7);
      exp_q.push_back(b);
    end
    @(negedge clk);
    start     = 1'b1;
    first_reg = 5'd0;
    last_reg  = 5'd7;
    byte_mode = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("emit1_valid_before_reset", 32'(out_valid), 32'd1);
    check("emit1_addr_before_reset", 32'(out_addr), 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check_zero("after_midreset");
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("no_done_after_reset", 32'(done), 32'd0);
      check("no_valid_after_reset", 32'(out_valid), 32'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    run_dump(5'd0,  5'd3,  1'b0, 0, 1'b0);
    run_dump(5'd3,  5'd3,  1'b0, 0, 1'b0);
    run_dump(5'd30, 5'd31, 1'b0, 1, 1'b0);
    run_dump(5'd1,  5'd2,  1'b1, 0, 1'b0);
    run_dump(5'd5,  5'd2,  1'b0, 0, 1'b0);
    run_dump(5'd31, 5'd31, 1'b1, 0, 1'b0);
    reset_mid_dump();
    run_dump(5'd0,  5'd7,  1'b0, 0, 1'b0);
    run_dump(5'd0,  5'd31, 1'b0, 2, 1'b1);
    for (int i = 0; i < 14; i++) begin
      run_dump(AW'($urandom), AW'($urandom), 1'($urandom), 2, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
